// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-select adder: block count helper,
// layout of the per-stage pipeline record, and the add/subtract mode encoding.
package csa_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  // Record layout, LSB first: valid, carry, partial sum, operand A, operand B.
  localparam int REC_VLD   = 0;
  localparam int REC_CARRY = 1;
  localparam int REC_SUM   = 2;

  function automatic int csa_nblk(input int width, input int block);
    return width / block;
  endfunction

  function automatic int rec_a_ofs(input int width);
    return REC_SUM + width;
  endfunction

  function automatic int rec_b_ofs(input int width);
    return REC_SUM + 2 * width;
  endfunction

  function automatic int rec_width(input int width);
    return REC_SUM + 3 * width;
  endfunction

endpackage

// File: rtl/csa_block.sv
// Combinational BLOCK-bit dual adder: produces both candidate results (carry-in
// 0 and carry-in 1) so the parent only has to select once the real carry lands.
module csa_block
  import csa_pkg::*;
#(
  parameter int BLOCK = 16
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] sum0,
  output logic [BLOCK-1:0] sum1,
  output logic             c0,
  output logic             c1
);

  assign {c0, sum0} = {1'b0, a} + {1'b0, b};
  assign {c1, sum1} = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready on both sides.
// One BLOCK-bit slice is resolved per stage; the whole pipe advances together
// whenever the output register is empty or being drained.
// Optional: define CSA_OVERFLOW_EN to add the registered signed-overflow port ovf.
module pipelined_carry_select_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BLOCK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CSA_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             c_out
);

  localparam int NBLK  = csa_nblk(WIDTH, BLOCK);
  localparam int RW    = rec_width(WIDTH);
  localparam int A_OFS = rec_a_ofs(WIDTH);
  localparam int B_OFS = rec_b_ofs(WIDTH);

  if (BLOCK < 1 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_params
    $error("pipelined_carry_select_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  mode_e            mode;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;
  logic             adv;
  logic             accept;

  logic [RW-1:0] src   [NBLK];
  logic [RW-1:0] rec_d [NBLK];
  logic [RW-1:0] rec_q [NBLK];

`ifdef CSA_OVERFLOW_EN
  logic ovf_d;
  logic ovf_q;
`endif

  assign mode   = mode_e'(sub);
  assign b_eff  = (mode == SUB) ? ~b : b;
  assign cin0   = (mode == SUB) ? 1'b1 : c_in;
  assign adv    = ~out_valid | out_ready;
  assign accept = in_valid & adv;

  assign in_ready  = adv;
  assign out_valid = rec_q[NBLK-1][REC_VLD];
  assign c_out     = rec_q[NBLK-1][REC_CARRY];
  assign sum       = rec_q[NBLK-1][REC_SUM +: WIDTH];

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    logic [BLOCK-1:0] blk_a, blk_b, s0, s1;
    logic             c0, c1, cin;
    logic [RW-1:0]    nxt;

    if (k == 0) begin : g_head
      assign src[k] = {b_eff, a, {WIDTH{1'b0}}, cin0, accept};
    end else begin : g_body
      assign src[k] = rec_q[k-1];
    end

    assign blk_a = src[k][A_OFS + k*BLOCK +: BLOCK];
    assign blk_b = src[k][B_OFS + k*BLOCK +: BLOCK];
    assign cin   = src[k][REC_CARRY];

    csa_block #(.BLOCK(BLOCK)) u_blk (
      .a    (blk_a),
      .b    (blk_b),
      .sum0 (s0),
      .sum1 (s1),
      .c0   (c0),
      .c1   (c1)
    );

    // Fold this block's selected result and carry into the travelling record.
    always_comb begin
      nxt                               = src[k];
      nxt[REC_SUM + k*BLOCK +: BLOCK]   = cin ? s1 : s0;
      nxt[REC_CARRY]                    = cin ? c1 : c0;
    end

    assign rec_d[k] = nxt;

`ifdef CSA_OVERFLOW_EN
    if (k == NBLK - 1) begin : g_ovf
      // Carry into the MSB recovered from a^b^sum at that bit, XOR carry out.
      assign ovf_d = blk_a[BLOCK-1] ^ blk_b[BLOCK-1]
                   ^ nxt[REC_SUM + WIDTH - 1] ^ nxt[REC_CARRY];
    end
`endif
  end

  // Pipeline registers: every stage shifts together on adv, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NBLK; k++) rec_q[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < NBLK; k++) rec_q[k] <= rec_d[k];
    end
  end

`ifdef CSA_OVERFLOW_EN
  // Overflow flag registered alongside the final stage's sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ovf_q <= 1'b0;
    else if (adv) ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Self-checking bench for pipelined_carry_select_adder (WIDTH=64, BLOCK=16).
// Random and directed beats are scored against a plain-arithmetic model queue.
module tb_pipelined_carry_select_adder;

  localparam int W    = 64;
  localparam int BLK  = 16;
  localparam int NBLK = W / BLK;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         c_in, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef CSA_OVERFLOW_EN
  logic         ovf;
`endif

  pipelined_carry_select_adder #(.WIDTH(W), .BLOCK(BLK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef CSA_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .c_out     (c_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           n_out = 0;
  logic         held = 1'b0;
  logic [W-1:0] held_sum;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: ordinary integer add/subtract, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ic, input logic is);
    exp_t         e;
    logic [W:0]   full;
    if (is) begin
      e.s = ia - ib;
      e.c = (ia >= ib);
      e.v = (ia[W-1] != ib[W-1]) && (e.s[W-1] != ia[W-1]);
    end else begin
      full = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
      e.s = full[W-1:0];
      e.c = full[W];
      e.v = (ia[W-1] == ib[W-1]) && (e.s[W-1] != ia[W-1]);
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rnd64();
    logic [W-1:0] r;
    case ($urandom_range(0, 7))
      0:       r = '1;
      1:       r = '0;
      2:       r = {1'b1, {(W-1){1'b0}}};
      3:       r = {1'b0, {(W-1){1'b1}}};
      default: r = {$urandom(), $urandom()};
    endcase
    return r;
  endfunction

  // One clock: drive at negedge, score handshakes, advance to next negedge.
  task automatic cycle(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic is, input logic ordy);
    exp_t e;
    in_valid  = v;
    a         = ia;
    b         = ib;
    c_in      = ic;
    sub       = is;
    out_ready = ordy;
    #1;
    if (held) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_sum", sum, held_sum);
    end
    check("in_ready", in_ready, !(out_valid && !out_ready));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sum", sum, e.s);
        check("c_out", c_out, e.c);
`ifdef CSA_OVERFLOW_EN
        check("ovf", ovf, e.v);
`endif
        n_out++;
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(ia, ib, ic, is));
    held     = out_valid && !out_ready;
    held_sum = sum;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 50) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Single beat into an empty pipe; leaves the result presented at out.
  task automatic single(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic is, input string tag);
    int lat;
    cycle(1'b1, ia, ib, ic, is, 1'b1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      lat++;
    end
    check({tag, "_latency"}, lat, NBLK);
  endtask

  initial begin
    int start_out;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_sum", sum, '0);
    check("rst_c_out", c_out, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full ripple through every block.
    single({W{1'b1}}, '0, 1'b1, 1'b0, "ripple");
    check("ripple_sum", sum, '0);
    check("ripple_c_out", c_out, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // 5 - 7 wraps with borrow.
    single(64'd5, 64'd7, 1'b1, 1'b1, "sub");
    check("sub_sum", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_c_out", c_out, 1'b0);
`ifdef CSA_OVERFLOW_EN
    check("sub_ovf", ovf, 1'b0);
`endif
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Signed overflow at the positive limit.
    single(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "ovf");
    check("ovf_sum", sum, 64'h8000_0000_0000_0000);
    check("ovf_c_out", c_out, 1'b0);
`ifdef CSA_OVERFLOW_EN
    check("ovf_flag", ovf, 1'b1);
`endif
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // 100 back-to-back beats at full rate.
    start_out = n_out;
    for (int i = 0; i < 100; i++)
      cycle(1'b1, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < NBLK; i++)
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("stream_count", n_out - start_out, 100);
    check("stream_empty", exp_q.size(), 0);

    // Three-cycle output stall in mid-stream.
    for (int i = 0; i < 6; i++)
      cycle(1'b1, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 6; i++)
      cycle(1'b1, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    drain();

    // Random valid and ready.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 3) != 0), rnd64(), rnd64(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    drain();

    // Reset with beats in flight.
    for (int i = 0; i < NBLK; i++)
      cycle(1'b1, rnd64() | 64'h1, rnd64(), 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sum", sum, '0);
    check("midrst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    held = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    single(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, "post_rst");
    check("post_rst_sum", sum, 64'h1234_5678_9ABC_DF00);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
